uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter for the UART link: accepts a parallel byte on a single-cycle start strobe and shifts out a standard 8N1 asynchronous frame (start bit, data LSB first, stop bit) on `O_TX`. Bit timing comes from the shared 16x-oversampling `I_BAUD_TICK` generator, so each bit lasts 16 ticks. It sits between the host/FIFO logic and the serial pin, and returns busy/done status so the producer can stream back-to-back bytes.

## Interface
- `DBIT`, 8: data bits per frame (legal range 5–8).
- `SB_TICK`, 16: ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `I_CLK` input 1: system clock, all logic on rising edge.
- `I_RSTF` input 1: reset, asynchronous and active-low.
- `I_BAUD_TICK` input 1: one-cycle pulse at 16x baud rate.
- `I_TX_START` input 1: request to transmit `I_DATA`; sampled only in idle.
- `I_DATA` input 8: byte to send; bits above `DBIT-1` ignored.
- `O_TX` output 1: serial line, registered, idles high.
- `O_TX_BUSY` output 1: high while a frame is in progress (state ≠ idle).
- `O_TX_DONE` output 1: one-cycle pulse at frame end.

## Operation
- Registers: state (2b), tick count `s` (5b, large enough for `SB_TICK-1` up to 31), bit count `b` (3b), shift reg `d` (8b), `O_TX` (1b), `O_TX_DONE` (1b).
- Reset: state=idle, `s`=0, `b`=0, `d`=0, `O_TX`=1, `O_TX_DONE`=0, `O_TX_BUSY`=0.
- **idle**: `O_TX`=1. If `I_TX_START`=1, then `d`←`I_DATA`, `s`←0, go to start. A tick in the acceptance cycle is not counted.
- **start**: `O_TX`=0. On tick: if `s`=15, go to data with `s`←0, `b`←0; else `s`←`s`+1.
- **data**: `O_TX`=`d[0]`. On tick: if `s`=15, then `s`←0 and `d`←`d`>>1; if `b`=`DBIT-1`, go to stop, else `b`←`b`+1. Otherwise `s`←`s`+1.
- **stop**: `O_TX`=1. On tick: if `s`=`SB_TICK-1`, go to idle and pulse `O_TX_DONE`; else `s`←`s`+1.
- `I_TX_START` and `I_DATA` are ignored outside idle. `I_DATA` need only be valid in the acceptance cycle.
- `O_TX` is driven from a register loaded from the next-state value, so the pin is glitch-free.

## Timing
- Acceptance at edge E: from E, `O_TX`=0 and `O_TX_BUSY`=1.
- Start bit lasts exactly 16 ticks. Each data bit lasts 16 ticks. Stop lasts `SB_TICK` ticks.
- Frame length is 16×(1+`DBIT`)+`SB_TICK` ticks; 160 with defaults.
- The edge that consumes the last stop tick sets state=idle, so `O_TX_BUSY`=0 and `O_TX_DONE`=1, for exactly one clock.
- Back-to-back: if `I_TX_START` is high in the `O_TX_DONE` cycle, the next frame is accepted at the following edge. The line then stays high for only that one clock beyond the stop period.
- `I_BAUD_TICK` wider than one cycle counts once per cycle. A tick-free period simply stalls the FSM, with the line held.
- Reset mid-frame: immediately `O_TX`=1, `O_TX_BUSY`=0, `O_TX_DONE`=0. The byte is discarded and no done pulse is issued.

## Test plan
- Reset value: hold `I_RSTF`=0 → `O_TX`=1, `O_TX_BUSY`=0, `O_TX_DONE`=0. Release with no start → line stays 1 indefinitely.
- Single byte 0xA5 with tick every 4 clocks → `O_TX` shows 0, then 1,0,1,0,0,1,0,1, then 1. Each level lasts 64 clocks. `O_TX_DONE` pulses once, 640 clocks after acceptance.
- Back-to-back 0x00 then 0xFF, with `I_TX_START` held high → second start bit begins exactly one clock after the first `O_TX_DONE`. Two done pulses occur, and a loopback `uart_rx` decodes 0x00 then 0xFF.
- Start while busy: pulse `I_TX_START` with `I_DATA`=0x3C mid-frame → ignored. Frame content is unchanged and there is exactly one done pulse.
- Reset mid-data-bit 3 → `O_TX`=1 asynchronously, no done pulse. A new frame with 0x55 afterwards is transmitted correctly.
- Parameters `DBIT`=7, `SB_TICK`=32 → frame is 160 ticks, 7 data bits, 2-bit-long stop. The 8th bit of `I_DATA` never appears on the line.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter paced by a shared 16x-oversampling baud tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       I_CLK,
  input  logic       I_RSTF,
  input  logic       I_BAUD_TICK,
  input  logic       I_TX_START,
  input  logic [7:0] I_DATA,
  output logic       O_TX,
  output logic       O_TX_BUSY,
  output logic       O_TX_DONE
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] B_LAST = 3'(DBIT - 1);
  state_t     state;
  logic [4:0] s;
  logic [2:0] b;
  logic [7:0] d;
  assign O_TX_BUSY = state != IDLE;
  // O_TX is loaded with the level of the state being entered, so the pin never glitches.
  always_ff @(posedge I_CLK or negedge I_RSTF)
    if (!I_RSTF) begin
      state     <= IDLE;
      s         <= '0;
      b         <= '0;
      d         <= '0;
      O_TX      <= 1'b1;
      O_TX_DONE <= 1'b0;
    end else begin
      O_TX_DONE <= 1'b0;
      case (state)
        IDLE:
          if (I_TX_START) begin
            state <= START;
            d     <= I_DATA;
            s     <= '0;
            O_TX  <= 1'b0;
          end
        START:
          if (I_BAUD_TICK) begin
            if (s == 5'd15) begin
              state <= DATA;
              s     <= '0;
              b     <= '0;
              O_TX  <= d[0];
            end else
              s <= s + 5'd1;
          end
        DATA:
          if (I_BAUD_TICK) begin
            if (s == 5'd15) begin
              s <= '0;
              d <= d >> 1;
              if (b == B_LAST) begin
                state <= STOP;
                O_TX  <= 1'b1;
              end else begin
                b    <= b + 3'd1;
                O_TX <= d[1];
              end
            end else
              s <= s + 5'd1;
          end
        STOP:
          if (I_BAUD_TICK) begin
            if (s == S_LAST) begin
              state     <= IDLE;
              O_TX_DONE <= 1'b1;
            end else
              s <= s + 5'd1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives a default and a DBIT=7/SB_TICK=32 transmitter in lockstep against a tick-count model.
module tb_uart_tx;
  logic       I_CLK = 1'b0;
  logic       I_RSTF = 1'b1;
  logic       I_BAUD_TICK = 1'b0;
  logic       I_TX_START = 1'b0;
  logic [7:0] I_DATA = 8'h00;
  logic       tx0, busy0, done0, tx1, busy1, done1;

  uart_tx u0 (
    .I_CLK(I_CLK), .I_RSTF(I_RSTF), .I_BAUD_TICK(I_BAUD_TICK), .I_TX_START(I_TX_START),
    .I_DATA(I_DATA), .O_TX(tx0), .O_TX_BUSY(busy0), .O_TX_DONE(done0)
  );
  uart_tx #(.DBIT(7), .SB_TICK(32)) u1 (
    .I_CLK(I_CLK), .I_RSTF(I_RSTF), .I_BAUD_TICK(I_BAUD_TICK), .I_TX_START(I_TX_START),
    .I_DATA(I_DATA), .O_TX(tx1), .O_TX_BUSY(busy1), .O_TX_DONE(done1)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [7:0] data;
    int         period;
    logic [9:0] line0;
    logic [8:0] line1;
    int         lat;
  } vec_t;
  vec_t tbl[5];

  int total = 0, bad = 0, wave_bad = 0, edges = 0, dones0 = 0;
  logic       m_busy[2];
  logic       m_done[2];
  int         m_n[2];
  logic [7:0] m_byte[2];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_cnt = -1;
  logic [7:0] rx_sh = 8'h00;

  function automatic int dbit(int u);
    return u != 0 ? 7 : 8;
  endfunction
  function automatic int flen(int u);
    return 16 * (1 + dbit(u)) + (u != 0 ? 32 : 16);
  endfunction
  function automatic logic exp_tx(int u);
    if (!m_busy[u]) return 1'b1;
    if (m_n[u] < 16) return 1'b0;
    if (m_n[u] < 16 * (1 + dbit(u))) return m_byte[u][(m_n[u] - 16) / 16];
    return 1'b1;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic tk, input logic st, input logic [7:0] dt);
    for (int u = 0; u < 2; u++) begin
      m_done[u] = 1'b0;
      if (!m_busy[u]) begin
        if (st) begin
          m_busy[u] = 1'b1;
          m_n[u]    = 0;
          m_byte[u] = dt;
          if (u == 0) exp_q.push_back(dt);
        end
      end else if (tk) begin
        m_n[u]++;
        if (m_n[u] == flen(u)) begin
          m_busy[u] = 1'b0;
          m_done[u] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_cycle(input logic tk);
    int k;
    if ({tx0, busy0, done0} !== {exp_tx(0), m_busy[0], m_done[0]}) wave_bad++;
    if ({tx1, busy1, done1} !== {exp_tx(1), m_busy[1], m_done[1]}) wave_bad++;
    if (done0) dones0++;
    if (rx_cnt < 0) begin
      if (!tx0) rx_cnt = 0;
    end else if (tk) begin
      rx_cnt++;
      if (rx_cnt % 16 == 8) begin
        k = rx_cnt / 16;
        if (k >= 1 && k <= 8) rx_sh[k-1] = tx0;
        if (k == 9) begin
          rx_q.push_back(rx_sh);
          rx_cnt = -1;
        end
      end
    end
  endtask

  task automatic cyc(input logic tk, input logic st, input logic [7:0] dt);
    I_BAUD_TICK = tk;
    I_TX_START  = st;
    I_DATA      = dt;
    @(posedge I_CLK);
    model_step(tk, st, dt);
    @(negedge I_CLK);
    cmp_cycle(tk);
    edges++;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (m_busy[0] || m_busy[1]); i++) cyc(1'b1, 1'b0, 8'h00);
    check("drain_idle", int'(busy0 | busy1), 0);
  endtask

  task automatic phase_end(input string nm);
    int mm = 0;
    check({nm, "_wave"}, wave_bad, 0);
    wave_bad = 0;
    check({nm, "_rx_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) mm++;
    check({nm, "_rx_data"}, mm, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input string nm);
    I_TX_START  = 1'b0;
    I_BAUD_TICK = 1'b0;
    #2 I_RSTF = 1'b0;
    #1;
    check({nm, "_tx0"}, tx0, 1);
    check({nm, "_busy0"}, busy0, 0);
    check({nm, "_done0"}, done0, 0);
    check({nm, "_tx1"}, tx1, 1);
    check({nm, "_busy1"}, busy1, 0);
    for (int u = 0; u < 2; u++) begin
      m_busy[u] = 1'b0;
      m_done[u] = 1'b0;
      m_n[u]    = 0;
    end
    rx_cnt = -1;
    rx_q.delete();
    exp_q.delete();
    @(negedge I_CLK);
    @(negedge I_CLK);
    check({nm, "_hold_tx0"}, tx0, 1);
    I_RSTF = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [9:0] l0 = '0;
    logic [8:0] l1 = '0;
    int lat0 = -1, lat1 = -1, nt;
    logic tk;
    cyc(1'b0, 1'b1, v.data);
    for (int i = 1; i <= 170 * v.period && (lat0 < 0 || lat1 < 0); i++) begin
      tk = (i % v.period) == 0;
      cyc(tk, 1'b0, 8'h00);
      nt = i / v.period;
      if (tk && nt % 16 == 8) begin
        if (nt / 16 < 10) l0[nt/16] = tx0;
        if (nt / 16 < 9) l1[nt/16] = tx1;
      end
      if (done0 && lat0 < 0) lat0 = i;
      if (done1 && lat1 < 0) lat1 = i;
    end
    check($sformatf("vec%0d_line8", idx), int'(l0), int'(v.line0));
    check($sformatf("vec%0d_line7", idx), int'(l1), int'(v.line1));
    check($sformatf("vec%0d_lat8", idx), lat0, v.lat);
    check($sformatf("vec%0d_lat7", idx), lat1, v.lat);
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int e_done, e_start, dc, d0;
    logic st;
    tbl[0] = '{8'hA5, 4, {1'b1, 8'hA5, 1'b0}, {1'b1, 7'h25, 1'b0}, 640};
    tbl[1] = '{8'hFF, 1, {1'b1, 8'hFF, 1'b0}, {1'b1, 7'h7F, 1'b0}, 160};
    tbl[2] = '{8'h00, 3, {1'b1, 8'h00, 1'b0}, {1'b1, 7'h00, 1'b0}, 480};
    tbl[3] = '{8'h80, 2, {1'b1, 8'h80, 1'b0}, {1'b1, 7'h00, 1'b0}, 320};
    tbl[4] = '{8'h55, 4, {1'b1, 8'h55, 1'b0}, {1'b1, 7'h55, 1'b0}, 640};

    @(negedge I_CLK);
    do_reset("rst_init");
    for (int i = 0; i < 100; i++) cyc(i % 2 == 0, 1'b0, 8'h00);
    check("idle_line", tx0, 1);
    phase_end("idle");

    for (int t = 0; t < 5; t++) run_vec(tbl[t], t);
    phase_end("table");

    // back-to-back with start held high
    e_done = -1; e_start = -1; dc = 0;
    for (int i = 0; i < 1000 && dc < 2; i++) begin
      cyc(i % 2 == 0, 1'b1, exp_q.size() == 0 ? 8'h00 : 8'hFF);
      if (done0) begin
        dc++;
        if (e_done < 0) e_done = edges;
      end else if (e_done >= 0 && e_start < 0 && !tx0) e_start = edges;
    end
    drain();
    check("b2b_dones", dc, 2);
    check("b2b_gap", e_start - e_done, 1);
    check("b2b_rx_first", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'h00);
    check("b2b_rx_second", rx_q.size() > 1 ? int'(rx_q[1]) : -1, 8'hFF);
    phase_end("b2b");

    // start pulse while busy is ignored
    d0 = dones0;
    cyc(1'b0, 1'b1, 8'hA5);
    for (int i = 1; i < 1000 && m_busy[0]; i++) cyc(i % 3 == 0, i == 200, i == 200 ? 8'h3C : 8'h00);
    drain();
    check("busy_start_dones", dones0 - d0, 1);
    check("busy_start_rx", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'hA5);
    phase_end("busy_start");

    // reset in the middle of data bit 3 (line low there for 0x66)
    cyc(1'b0, 1'b1, 8'h66);
    for (int i = 1; i < 2000 && m_n[0] < 70; i++) cyc(i % 2 == 0, 1'b0, 8'h00);
    check("pre_rst_line", tx0, 0);
    check("mid_wave", wave_bad, 0);
    wave_bad = 0;
    d0 = dones0;
    do_reset("rst_mid");
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 8'h00);
    check("rst_no_done", dones0 - d0, 0);
    cyc(1'b0, 1'b1, 8'h55);
    for (int i = 1; i < 2000 && m_busy[0]; i++) cyc(i % 4 == 0, 1'b0, 8'h00);
    drain();
    check("after_rst_rx", rx_q.size() > 0 ? int'(rx_q[0]) : -1, 8'h55);
    phase_end("after_rst");

    for (int i = 0; i < 8000; i++) begin
      st = $urandom_range(0, 40) == 0;
      cyc($urandom_range(0, 2) == 0, st, 8'($urandom));
    end
    drain();
    phase_end("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
